mod5_residue_sched: RTL

//  Shares one combinational 32-bit mod-5 residue unit (div_32_5) among N_REQ requesters.

---
 rtl/mod5_residue_sched.sv | 97 +++++++++
 1 files changed

// File: rtl/mod5_residue_sched.sv
// mod5_residue_sched: round-robin share of one combinational mod-5 unit among N_REQ
// valid/ready requesters, with a registered operand, a registered residue and a single result channel.

module div_32_5 (
    input  logic [31:0] x_i,
    output logic [2:0]  r_o
);
    // 16 == 1 (mod 5), so the sum of the hex digits has the same residue as x.
    logic [6:0] sum;
    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) sum = sum + 7'(x_i[i*4 +: 4]);
        r_o = 3'(sum % 7'd5);
    end
endmodule

module mod5_residue_sched #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2:0]              res_r,
    output logic [ID_W-1:0]         res_id,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_q, id_q, gnt, cand;
    logic [ID_W:0]     sum;
    logic              found;
    logic [DATA_W-1:0] opnd_q;
    logic [2:0]        r;

    div_32_5 u_div (.x_i(opnd_q), .r_o(r));

    // Scan downward so the requester closest to rr_q wins.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        sum   = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum  = {1'b0, rr_q} + (ID_W+1)'(k);
            cand = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ)) : ID_W'(sum);
            if (req_valid[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = found ? CALC : IDLE;
            CALC:    state_d = RESP;
            RESP:    state_d = res_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE && found && rst_n) ? (N_REQ'(1) << gnt) : '0;
        res_valid = state_q == RESP;
        busy      = state_q != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            opnd_q  <= '0;
            id_q    <= '0;
            res_r   <= '0;
            res_id  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && found) begin
                opnd_q <= req_data[int'(gnt)*DATA_W +: DATA_W];
                id_q   <= gnt;
                rr_q   <= (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + ID_W'(1);
            end
            if (state_q == CALC) begin
                res_r  <= r;
                res_id <= id_q;
            end
        end
    end
endmodule
